// File: rtl/seqmul_param.sv
// seqmul_param: iterative multiplier retiring BITS_PER_CYCLE multiplier bits per clock; SEQMUL_SIGNED_EN adds signed_mode.
// Latency N+1 cycles from accepted start to done pulse; start is ignored while busy and never queued.
module seqmul_param #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQMUL_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplr;
    logic [WIDTH-1:0]     acc;
    logic [CW-1:0]        count;
    logic                 neg;

    logic                 accept;
    logic                 last;
    logic [WIDTH+K-1:0]   mc_ext;
    logic [WIDTH+K-1:0]   mp_ext;
    logic [WIDTH+K-1:0]   pp;
    logic [WIDTH+K-1:0]   sum;
    logic [2*WIDTH+K-1:0] shifted_full;
    logic [2*WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0]   prod_final;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_in;

    // One radix-2^K step: the sum cannot overflow W+K bits, so no carry is lost.
    always_comb begin
        mc_ext       = {{K{1'b0}}, mcand};
        mp_ext       = {{WIDTH{1'b0}}, mplr[K-1:0]};
        pp           = mc_ext * mp_ext;
        sum          = pp + {{K{1'b0}}, acc};
        shifted_full = {sum, mplr} >> K;
        shifted      = shifted_full[2*WIDTH-1:0];
        prod_final   = neg ? (~shifted + {{(2*WIDTH-1){1'b0}}, 1'b1}) : shifted;
        last         = (count == CW'(N - 1));
    end

`ifdef SEQMUL_SIGNED_EN
    // Signed ops run on magnitudes; the most negative value still fits as an unsigned magnitude.
    always_comb begin
        neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        a_mag  = (signed_mode && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
        b_mag  = (signed_mode && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    end
`else
    always_comb begin
        neg_in = 1'b0;
        a_mag  = a;
        b_mag  = b;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else if (accept) begin
            mcand <= a_mag;
            mplr  <= b_mag;
            acc   <= '0;
            count <= '0;
            neg   <= neg_in;
        end else if (state == RUN) begin
            acc   <= shifted[2*WIDTH-1:WIDTH];
            mplr  <= shifted[WIDTH-1:0];
            count <= count + CW'(1);
            if (last) begin
                result <= prod_final;
            end
        end
    end

endmodule

// File: tb/tb_seqmul_param.sv
// Directed bench for seqmul_param: 64-bit K=1 and K=4 instances plus 8-bit K=1/2/8 instances sharing inputs.
module tb_seqmul_param;

    logic         clk;
    logic         rst;

    logic         k1_start;
    logic [63:0]  k1_a, k1_b;
    logic         k1_busy, k1_done;
    logic [127:0] k1_res;

    logic         k4_start;
    logic [63:0]  k4_a, k4_b;
    logic         k4_busy, k4_done;
    logic [127:0] k4_res;

    logic         w_start;
    logic [7:0]   w_a, w_b;
    logic         w1_busy, w1_done, w2_busy, w2_done, w8_busy, w8_done;
    logic [15:0]  w1_res, w2_res, w8_res;

`ifdef SEQMUL_SIGNED_EN
    logic         k1_sm, k4_sm, w_sm;
`endif

    int errors = 0;
    int checks = 0;

    seqmul_param #(.WIDTH(64), .BITS_PER_CYCLE(1)) u_k1 (
        .clk(clk), .rst(rst), .start(k1_start), .a(k1_a), .b(k1_b),
`ifdef SEQMUL_SIGNED_EN
        .signed_mode(k1_sm),
`endif
        .busy(k1_busy), .done(k1_done), .result(k1_res));

    seqmul_param #(.WIDTH(64), .BITS_PER_CYCLE(4)) u_k4 (
        .clk(clk), .rst(rst), .start(k4_start), .a(k4_a), .b(k4_b),
`ifdef SEQMUL_SIGNED_EN
        .signed_mode(k4_sm),
`endif
        .busy(k4_busy), .done(k4_done), .result(k4_res));

    seqmul_param #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w1 (
        .clk(clk), .rst(rst), .start(w_start), .a(w_a), .b(w_b),
`ifdef SEQMUL_SIGNED_EN
        .signed_mode(w_sm),
`endif
        .busy(w1_busy), .done(w1_done), .result(w1_res));

    seqmul_param #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_w2 (
        .clk(clk), .rst(rst), .start(w_start), .a(w_a), .b(w_b),
`ifdef SEQMUL_SIGNED_EN
        .signed_mode(w_sm),
`endif
        .busy(w2_busy), .done(w2_done), .result(w2_res));

    seqmul_param #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_w8 (
        .clk(clk), .rst(rst), .start(w_start), .a(w_a), .b(w_b),
`ifdef SEQMUL_SIGNED_EN
        .signed_mode(w_sm),
`endif
        .busy(w8_busy), .done(w8_done), .result(w8_res));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start on the K=1 instance and returns the cycle of done (counted from the accepting edge).
    task automatic run_k1(input logic [63:0] av, input logic [63:0] bv, output int lat, output int bad);
        lat = -1; bad = 0;
        k1_a = av; k1_b = bv; k1_start = 1'b1;
        @(negedge clk);
        k1_start = 1'b0; k1_a = 64'h0; k1_b = 64'h1234;
        for (int i = 1; i <= 200; i++) begin
            if (k1_busy && k1_done) bad++;
            if (k1_done) begin lat = i; break; end
            if (!k1_busy) bad++;
            @(negedge clk);
        end
    endtask

    task automatic run_k4(input logic [63:0] av, input logic [63:0] bv, output int lat, output int bad);
        lat = -1; bad = 0;
        k4_a = av; k4_b = bv; k4_start = 1'b1;
        @(negedge clk);
        k4_start = 1'b0; k4_a = 64'h5; k4_b = 64'h6;
        for (int i = 1; i <= 60; i++) begin
            if (k4_busy && k4_done) bad++;
            if (k4_done) begin lat = i; break; end
            if (!k4_busy) bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({k1_busy, k1_done} !== 2'b00 || k1_res !== 128'h0) begin
            errors++; $display("FAIL reset_k1 busy=%b done=%b result=%h expected 0/0/0", k1_busy, k1_done, k1_res);
        end
        checks++;
        if ({k4_busy, k4_done} !== 2'b00 || k4_res !== 128'h0) begin
            errors++; $display("FAIL reset_k4 busy=%b done=%b result=%h expected 0/0/0", k4_busy, k4_done, k4_res);
        end
        checks++;
        if ({w1_busy, w1_done, w2_busy, w2_done, w8_busy, w8_done} !== 6'b0 ||
            w1_res !== 16'h0 || w2_res !== 16'h0 || w8_res !== 16'h0) begin
            errors++; $display("FAIL reset_w8 results=%h/%h/%h expected 0", w1_res, w2_res, w8_res);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_k1;
        int lat, bad;
        run_k1(64'd3, 64'd5, lat, bad);
        checks++;
        if (lat !== 65) begin errors++; $display("FAIL basic_latency got=%0d expected=65", lat); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL basic_busy_profile bad_cycles=%0d expected=0", bad); end
        checks++;
        if (k1_res !== 128'd15) begin errors++; $display("FAIL basic_result got=%h expected=%h", k1_res, 128'd15); end
        repeat (4) @(negedge clk);
        checks++;
        if (k1_res !== 128'd15 || k1_done !== 1'b0 || k1_busy !== 1'b0) begin
            errors++; $display("FAIL basic_hold result=%h done=%b busy=%b expected 15/0/0", k1_res, k1_done, k1_busy);
        end
    endtask

    task automatic test_extremes;
        int lat, bad;
        run_k1(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, bad);
        checks++;
        if (k1_res !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 || lat !== 65) begin
            errors++; $display("FAIL extreme_ones result=%h lat=%0d expected fffffffffffffffe0000000000000001 lat 65", k1_res, lat);
        end
        @(negedge clk);
        run_k1(64'h0, 64'hF0F0_F0F0_F0F0_F0F0, lat, bad);
        checks++;
        if (k1_res !== 128'h0 || lat !== 65) begin
            errors++; $display("FAIL extreme_zero result=%h lat=%0d expected 0 lat 65", k1_res, lat);
        end
    endtask

    task automatic test_handshake_k4;
        int lat, bad;
        lat = -1; bad = 0;
        k4_a = 64'd7; k4_b = 64'd9; k4_start = 1'b1;
        @(negedge clk);
        k4_start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 3) begin k4_start = 1'b1; k4_a = 64'd100; k4_b = 64'd100; end
            if (i == 4) k4_start = 1'b0;
            if (i == 5) begin k4_a = 64'd55; k4_b = 64'd77; end
            if (k4_busy && k4_done) bad++;
            if (k4_done) begin lat = i; break; end
            if (!k4_busy) bad++;
            @(negedge clk);
        end
        checks++;
        if (lat !== 17 || bad !== 0) begin errors++; $display("FAIL hs_first_latency got=%0d bad=%0d expected 17/0", lat, bad); end
        checks++;
        if (k4_res !== 128'd63) begin errors++; $display("FAIL hs_first_result got=%h expected=%h", k4_res, 128'd63); end
        // Still in the done cycle: back-to-back accept.
        run_k4(64'd2, 64'd11, lat, bad);
        checks++;
        if (lat !== 17 || bad !== 0) begin errors++; $display("FAIL hs_b2b_latency got=%0d bad=%0d expected 17/0", lat, bad); end
        checks++;
        if (k4_res !== 128'd22) begin errors++; $display("FAIL hs_b2b_result got=%h expected=%h", k4_res, 128'd22); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int lat, bad, stray;
        stray = 0;
        k4_a = 64'd12; k4_b = 64'd13; k4_start = 1'b1;
        @(negedge clk);
        k4_start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (k4_busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before_rst got=%b expected=1", k4_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (k4_busy !== 1'b0 || k4_done !== 1'b0 || k4_res !== 128'h0) begin
            errors++; $display("FAIL midop_after_rst busy=%b done=%b result=%h expected 0/0/0", k4_busy, k4_done, k4_res);
        end
        for (int i = 0; i < 30; i++) begin
            if (k4_done || k4_busy) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL midop_no_done stray_cycles=%0d expected=0", stray); end
        run_k4(64'd12, 64'd13, lat, bad);
        checks++;
        if (k4_res !== 128'd156 || lat !== 17) begin
            errors++; $display("FAIL midop_restart result=%h lat=%0d expected 9c lat 17", k4_res, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep_w8;
        logic [7:0]  vals [10];
        logic [15:0] expv;
        int l1, l2, l8;
        vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80, 8'hAA, 8'h55, 8'hFE, 8'hFF};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                w_a = vals[i]; w_b = vals[j]; w_start = 1'b1;
                expv = {8'h00, vals[i]} * {8'h00, vals[j]};
                l1 = -1; l2 = -1; l8 = -1;
                @(negedge clk);
                w_start = 1'b0; w_a = 8'h3C; w_b = 8'hC3;
                for (int c = 1; c <= 12; c++) begin
                    if (w1_done && l1 < 0) l1 = c;
                    if (w2_done && l2 < 0) l2 = c;
                    if (w8_done && l8 < 0) l8 = c;
                    @(negedge clk);
                end
                checks++;
                if (w1_res !== expv || l1 !== 9) begin
                    errors++; $display("FAIL sweep_k1 a=%h b=%h result=%h lat=%0d expected %h lat 9", vals[i], vals[j], w1_res, l1, expv);
                end
                checks++;
                if (w2_res !== expv || l2 !== 5) begin
                    errors++; $display("FAIL sweep_k2 a=%h b=%h result=%h lat=%0d expected %h lat 5", vals[i], vals[j], w2_res, l2, expv);
                end
                checks++;
                if (w8_res !== expv || l8 !== 2) begin
                    errors++; $display("FAIL sweep_k8 a=%h b=%h result=%h lat=%0d expected %h lat 2", vals[i], vals[j], w8_res, l8, expv);
                end
            end
        end
    endtask

`ifdef SEQMUL_SIGNED_EN
    task automatic test_signed;
        int lat, bad;
        k4_sm = 1'b1;
        run_k4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, bad);
        checks++;
        if (k4_res !== 128'd1 || lat !== 17) begin
            errors++; $display("FAIL signed_m1_m1 result=%h lat=%0d expected 1 lat 17", k4_res, lat);
        end
        @(negedge clk);
        run_k4(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, lat, bad);
        checks++;
        if (k4_res !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1) begin
            errors++; $display("FAIL signed_m3_5 result=%h expected fffffffffffffffffffffffffffffff1", k4_res);
        end
        @(negedge clk);
        k4_sm = 1'b0;
        run_k4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, bad);
        checks++;
        if (k4_res !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
            errors++; $display("FAIL signed_off_ones result=%h expected fffffffffffffffe0000000000000001", k4_res);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        k1_start = 1'b0; k1_a = '0; k1_b = '0;
        k4_start = 1'b0; k4_a = '0; k4_b = '0;
        w_start  = 1'b0; w_a  = '0; w_b  = '0;
`ifdef SEQMUL_SIGNED_EN
        k1_sm = 1'b0; k4_sm = 1'b0; w_sm = 1'b0;
`endif
        @(negedge clk);
        test_reset;
        test_basic_k1;
        test_extremes;
        test_handshake_k4;
        test_reset_midop;
        test_sweep_w8;
`ifdef SEQMUL_SIGNED_EN
        test_signed;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
